// File: rtl/mm_seq_pkg.sv
// Shared constants, state encoding and helpers for the host-command sequencer.
package mm_seq_pkg;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int unsigned N = 16;

    localparam logic [7:0] CMD_LOAD_A  = 8'h01;
    localparam logic [7:0] CMD_LOAD_B  = 8'h02;
    localparam logic [7:0] CMD_COMPUTE = 8'h03;
    localparam logic [7:0] CMD_PING    = 8'h04;

    localparam logic [7:0] STAT_OK = 8'h00;
    localparam logic [7:0] STAT_E1 = 8'hE1;  // checksum mismatch
    localparam logic [7:0] STAT_E2 = 8'hE2;  // unknown command
    localparam logic [7:0] STAT_E3 = 8'hE3;  // inter-byte timeout
    localparam logic [7:0] STAT_E4 = 8'hE4;  // compute without both operands

    typedef enum logic [3:0] {
        StIdle,
        StCmd,
        StPayload,
        StCsum,
        StRun,
        StWait,
        StRSync,
        StRStat,
        StRRd,
        StRHi,
        StRLo,
        StRCsum
    } state_e;

    function automatic logic known_cmd(input logic [7:0] c);
        return (c == CMD_LOAD_A) || (c == CMD_LOAD_B) || (c == CMD_COMPUTE) || (c == CMD_PING);
    endfunction

endpackage

// File: rtl/mm_byte_tx.sv
// Single-byte transmit holder: keeps tx_data/tx_valid stable until the link accepts the byte.
module mm_byte_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       accepted
);

    assign accepted = tx_valid && tx_ready;

    // load is only issued while empty or in the accepting cycle, so a held byte never changes
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else if (load) begin
            tx_valid <= 1'b1;
            tx_data  <= load_data;
        end else if (accepted) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mm_host_seq.sv
// Framed host-command sequencer between the UART byte link and the 4x4 matrix-multiply engine.
// Define MM_SEQ_TIMEOUT_EN to abort a stalled host frame after TIMEOUT idle cycles (status E3).
module mm_host_seq
    import mm_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        ld_we,
    output logic        ld_sel,
    output logic [3:0]  ld_addr,
    output logic [7:0]  ld_data,
    output logic        eng_start,
    input  logic        eng_done,
    output logic [3:0]  res_addr,
    input  logic [15:0] res_data,
    output logic        busy,
    output logic        err
);

    localparam logic [3:0] LastIdx = 4'(N - 1);

    state_e     state_q;
    logic [7:0] cmd_q;
    logic [7:0] stat_q;
    logic [7:0] csum_q;
    logic [3:0] idx_q;
    logic       rd_ph_q;
    logic [7:0] lo_q;
    logic       a_ok_q;
    logic       b_ok_q;

    logic       tx_load;
    logic [7:0] tx_byte;
    logic       tx_accept;
    logic [7:0] frame_stat;
    logic       run_go;
    logic       has_data;
    logic       in_frame;
    logic       timeout_hit;

    mm_byte_tx u_byte_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (tx_load),
        .load_data (tx_byte),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .accepted  (tx_accept)
    );

    assign busy     = (state_q != StIdle);
    assign in_frame = (state_q == StCmd) || (state_q == StPayload) || (state_q == StCsum);
    assign has_data = (stat_q == STAT_OK) && (cmd_q == CMD_COMPUTE);

`ifdef MM_SEQ_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT + 1);
    logic [ToW-1:0] to_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst || !in_frame || rx_valid) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = in_frame && !rx_valid && (to_cnt_q == ToW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
    assign timeout_hit    = 1'b0;
`endif

    // Status the current frame ends with if the byte in hand is its checksum
    always_comb begin
        frame_stat = STAT_OK;
        if (rx_data != csum_q) begin
            frame_stat = STAT_E1;
        end else if (stat_q != STAT_OK) begin
            frame_stat = stat_q;
        end else if ((cmd_q == CMD_COMPUTE) && !(a_ok_q && b_ok_q)) begin
            frame_stat = STAT_E4;
        end
        run_go = (frame_stat == STAT_OK) && (cmd_q == CMD_COMPUTE);
    end

    always_comb begin
        tx_load = 1'b0;
        tx_byte = SYNC;
        unique case (state_q)
            StCsum:  tx_load = rx_valid && !run_go;
            StWait:  tx_load = eng_done;
            StRSync: begin
                tx_load = tx_accept;
                tx_byte = stat_q;
            end
            StRStat: begin
                tx_load = tx_accept && !has_data;
                tx_byte = stat_q;
            end
            StRRd: begin
                tx_load = rd_ph_q;
                tx_byte = res_data[15:8];
            end
            StRHi: begin
                tx_load = tx_accept;
                tx_byte = lo_q;
            end
            StRLo: begin
                tx_load = tx_accept && (idx_q == LastIdx);
                tx_byte = csum_q;
            end
            default: ;
        endcase
        if (timeout_hit) begin
            tx_load = 1'b1;
            tx_byte = SYNC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            cmd_q     <= 8'h00;
            stat_q    <= STAT_OK;
            csum_q    <= 8'h00;
            idx_q     <= 4'd0;
            rd_ph_q   <= 1'b0;
            lo_q      <= 8'h00;
            a_ok_q    <= 1'b0;
            b_ok_q    <= 1'b0;
            err       <= 1'b0;
            eng_start <= 1'b0;
            ld_we     <= 1'b0;
            ld_sel    <= 1'b0;
            ld_addr   <= 4'd0;
            ld_data   <= 8'h00;
            res_addr  <= 4'd0;
        end else begin
            ld_we     <= 1'b0;
            eng_start <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rx_valid && (rx_data == SYNC)) state_q <= StCmd;
                end
                StCmd: begin
                    if (rx_valid) begin
                        cmd_q  <= rx_data;
                        csum_q <= rx_data;
                        idx_q  <= 4'd0;
                        stat_q <= known_cmd(rx_data) ? STAT_OK : STAT_E2;
                        if (rx_data == CMD_LOAD_A) begin
                            a_ok_q  <= 1'b0;
                            state_q <= StPayload;
                        end else if (rx_data == CMD_LOAD_B) begin
                            b_ok_q  <= 1'b0;
                            state_q <= StPayload;
                        end else begin
                            state_q <= StCsum;
                        end
                    end
                end
                StPayload: begin
                    if (rx_valid) begin
                        ld_we   <= 1'b1;
                        ld_sel  <= (cmd_q == CMD_LOAD_B);
                        ld_addr <= idx_q;
                        ld_data <= rx_data;
                        csum_q  <= csum_q ^ rx_data;
                        idx_q   <= idx_q + 4'd1;
                        if (idx_q == LastIdx) state_q <= StCsum;
                    end
                end
                StCsum: begin
                    if (rx_valid) begin
                        stat_q <= frame_stat;
                        err    <= (frame_stat != STAT_OK);
                        if (run_go) begin
                            eng_start <= 1'b1;
                            state_q   <= StRun;
                        end else begin
                            state_q <= StRSync;
                        end
                        if ((frame_stat == STAT_OK) && (cmd_q == CMD_LOAD_A)) a_ok_q <= 1'b1;
                        if ((frame_stat == STAT_OK) && (cmd_q == CMD_LOAD_B)) b_ok_q <= 1'b1;
                    end
                end
                StRun:   state_q <= StWait;
                StWait: begin
                    if (eng_done) state_q <= StRSync;
                end
                StRSync: begin
                    if (tx_accept) begin
                        csum_q  <= stat_q;
                        state_q <= StRStat;
                    end
                end
                StRStat: begin
                    if (tx_accept) begin
                        if (has_data) begin
                            idx_q    <= 4'd0;
                            res_addr <= 4'd0;
                            rd_ph_q  <= 1'b0;
                            state_q  <= StRRd;
                        end else begin
                            state_q <= StRCsum;
                        end
                    end
                end
                StRRd: begin
                    // first cycle presents res_addr, second captures the word
                    if (!rd_ph_q) begin
                        rd_ph_q <= 1'b1;
                    end else begin
                        rd_ph_q <= 1'b0;
                        lo_q    <= res_data[7:0];
                        csum_q  <= csum_q ^ res_data[15:8];
                        state_q <= StRHi;
                    end
                end
                StRHi: begin
                    if (tx_accept) begin
                        csum_q  <= csum_q ^ lo_q;
                        state_q <= StRLo;
                    end
                end
                StRLo: begin
                    if (tx_accept) begin
                        if (idx_q == LastIdx) begin
                            state_q <= StRCsum;
                        end else begin
                            idx_q    <= idx_q + 4'd1;
                            res_addr <= idx_q + 4'd1;
                            state_q  <= StRRd;
                        end
                    end
                end
                StRCsum: begin
                    if (tx_accept) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
            if (timeout_hit) begin
                stat_q  <= STAT_E3;
                err     <= 1'b1;
                state_q <= StRSync;
            end
        end
    end

endmodule

// File: tb/tb_mm_host_seq.sv
// Scoreboard bench for mm_host_seq: directed host frames, queued expected tx bytes, engine model.
module tb_mm_host_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        ld_we;
    logic        ld_sel;
    logic [3:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        eng_start;
    logic        eng_done;
    logic [3:0]  res_addr;
    logic [15:0] res_data;
    logic        busy;
    logic        err;

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;
    int ld_cnt = 0;
    int start_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  a_mem[16];
    logic [7:0]  b_mem[16];
    logic [15:0] r_mem[16];
    logic [7:0]  pay[16];
    logic        hold_q = 1'b0;
    logic [7:0]  hold_data = 8'h00;

    mm_host_seq #(.TIMEOUT(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .ld_we     (ld_we),
        .ld_sel    (ld_sel),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .eng_start (eng_start),
        .eng_done  (eng_done),
        .res_addr  (res_addr),
        .res_data  (res_data),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) res_data <= r_mem[res_addr];

    // Monitor: pops the scoreboard on each tx transfer and checks held bytes stay put
    initial begin
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold_q = 1'b0;
            end else begin
                if (hold_q) begin
                    tests++;
                    if (!tx_valid || tx_data != hold_data) begin
                        fails++;
                        $display("FAIL tx_hold: valid=%0b data=%02h, required valid=1 data=%02h",
                                 tx_valid, tx_data, hold_data);
                    end
                end
                if (tx_valid && tx_ready) begin
                    acc_cnt++;
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL tx_byte: got %02h, required no byte", tx_data);
                    end else begin
                        want = exp_q.pop_front();
                        if (tx_data != want) begin
                            fails++;
                            $display("FAIL tx_byte #%0d: got %02h, required %02h",
                                     acc_cnt, tx_data, want);
                        end
                    end
                end
                if (ld_we) begin
                    ld_cnt++;
                    if (ld_sel) b_mem[ld_addr] = ld_data;
                    else        a_mem[ld_addr] = ld_data;
                end
                if (eng_start) start_cnt++;
                hold_q    = tx_valid && !tx_ready;
                hold_data = tx_data;
            end
        end
    end

    // Engine model: multiplies the captured operands, answers with eng_done 5 cycles later
    initial begin
        logic [15:0] acc;
        eng_done = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_start) begin
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        acc = 16'h0;
                        for (int k = 0; k < 4; k++) begin
                            acc = acc + 16'(a_mem[i*4+k]) * 16'(b_mem[k*4+j]);
                        end
                        r_mem[i*4+j] = acc;
                    end
                end
                repeat (5) @(posedge clk);
                #1 eng_done = 1'b1;
                @(posedge clk);
                #1 eng_done = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_load(input logic [7:0] cmd, input logic [7:0] cs);
        send_byte(8'hA5);
        send_byte(cmd);
        for (int i = 0; i < 16; i++) send_byte(pay[i]);
        send_byte(cs);
    endtask

    task automatic push3(input logic [7:0] st);
        exp_q.push_back(8'hA5);
        exp_q.push_back(st);
        exp_q.push_back(st);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 4000) begin
            @(posedge clk);
            n++;
        end
        tests++;
        if (n >= 4000) begin
            fails++;
            $display("FAIL %s: %0d bytes still expected, busy=%0b, required 0 and 0",
                     name, exp_q.size(), busy);
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int base;
        int n;
        rst      = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_mem[i] = 8'h00;
            b_mem[i] = 8'h00;
            r_mem[i] = 16'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({tx_valid, tx_data, ld_we, ld_sel, ld_addr, ld_data, eng_start,
                                    res_addr, busy, err}), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Good loads of A = 1..16 and B = identity, then compute under tx back-pressure
        for (int i = 0; i < 16; i++) pay[i] = 8'(i + 1);
        push3(8'h00);
        send_load(8'h01, 8'h11);
        wait_done("load_a");
        for (int i = 0; i < 16; i++) pay[i] = (i % 5 == 0) ? 8'h01 : 8'h00;
        push3(8'h00);
        send_load(8'h02, 8'h02);
        wait_done("load_b");
        check("ld_we_count", 32'(ld_cnt), 32'd32);

        tx_ready = 1'b0;
        base = acc_cnt;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h00);
            exp_q.push_back(8'(i + 1));
        end
        exp_q.push_back(8'h10);
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h03);
        n = 0;
        while (!tx_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("compute_first_valid", 32'(tx_valid), 32'd1);
        repeat (50) @(posedge clk);
        #1 tx_ready = 1'b1;
        wait_done("compute");
        check("compute_bytes", 32'(acc_cnt - base), 32'd35);
        check("start_once", 32'(start_cnt), 32'd1);
        check("err_after_ok", 32'(err), 32'd0);

        // Bad checksum on load A, then compute must be refused
        for (int i = 0; i < 16; i++) pay[i] = 8'(i + 1);
        push3(8'hE1);
        send_load(8'h01, 8'h00);
        wait_done("bad_csum");
        check("err_after_e1", 32'(err), 32'd1);
        push3(8'hE4);
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h03);
        wait_done("compute_e4");
        check("start_not_again", 32'(start_cnt), 32'd1);

        // Unknown command
        base = ld_cnt;
        push3(8'hE2);
        send_byte(8'hA5);
        send_byte(8'h07);
        send_byte(8'h07);
        wait_done("unknown_cmd");
        check("no_ld_on_e2", 32'(ld_cnt - base), 32'd0);
        check("err_after_e2", 32'(err), 32'd1);

        // Junk bytes in IDLE produce nothing; ping answers one cycle after its checksum
        base = acc_cnt;
        send_byte(8'h33);
        send_byte(8'h04);
        repeat (5) @(posedge clk);
        check("idle_junk_busy", 32'(busy), 32'd0);
        check("idle_junk_tx", 32'(acc_cnt - base), 32'd0);
        push3(8'h00);
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h04);
        @(negedge clk);
        check("ping_latency", 32'(tx_valid), 32'd1);
        wait_done("ping");
        check("err_cleared", 32'(err), 32'd0);

        // Reload A, start compute, reset while the first result high byte is held
        push3(8'h00);
        send_load(8'h01, 8'h11);
        wait_done("reload_a");
        base = acc_cnt;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00);
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h03);
        n = 0;
        while (acc_cnt < base + 2 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        tx_ready = 1'b0;
        n = 0;
        while (!tx_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rhi_reached", 32'(tx_valid), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midresp_reset", 32'({tx_valid, tx_data, ld_we, ld_sel, ld_addr, ld_data, eng_start,
                                    res_addr, busy, err}), 32'h0);
        check("midresp_queue", 32'(exp_q.size()), 32'd0);
        check("midresp_start", 32'(start_cnt), 32'd2);
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        push3(8'hE4);
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h03);
        wait_done("compute_after_reset");
        push3(8'h00);
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h04);
        wait_done("ping_after_reset");
        check("err_final", 32'(err), 32'd0);

`ifdef MM_SEQ_TIMEOUT_EN
        push3(8'hE3);
        send_byte(8'hA5);
        send_byte(8'h01);
        for (int i = 0; i < 5; i++) send_byte(8'(i + 1));
        n = 0;
        while (!tx_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("timeout_window", 32'((n >= 60) && (n <= 70)), 32'd1);
        wait_done("timeout");
        check("err_after_e3", 32'(err), 32'd1);
        push3(8'h00);
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h04);
        wait_done("ping_after_timeout");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
